median_channel_scheduler: RTL and testbench

//  Shares one free-running 5-tap pipelined median engine (no valid of its own) between NCH input channels.
//  - Holds a 5-sample window per channel.
//  - Picks pending samples round-robin and drives the engine with the updated window.
//  - Tracks each issue through the engine latency and returns a channel-tagged median.

---
 rtl/median_channel_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_median_channel_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_channel_scheduler.sv
// Round-robin front end that shares one free-running 5-tap median engine between NCH
// sample channels, tagging each issue through the engine latency to label its result.

module median_chan_lane #(
    parameter int W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               strobe_i,
    input  logic [W-1:0]       data_i,
    input  logic               grant_i,
    input  logic               clr_ovr_i,
    output logic               pend_o,
    output logic [4:0][W-1:0]  win_o,
    output logic               primed_o,
    output logic               overrun_o
);
    logic              pend_q, pend_d;
    logic [W-1:0]      pdata_q, pdata_d;
    logic [4:0][W-1:0] win_q, win_d, win_shift;
    logic [2:0]        fill_q, fill_d;
    logic              ovr_q, ovr_d;
    logic              cap;

    assign cap       = strobe_i & en_i;
    // Element 0 is the newest sample; the oldest falls off element 4.
    assign win_shift = {win_q[3:0], pdata_q};

    always_comb begin
        pdata_d = cap ? data_i : pdata_q;
        ovr_d   = (cap & pend_q & ~grant_i) | (ovr_q & ~clr_ovr_i);
        pend_d  = 1'b0;
        win_d   = '0;
        fill_d  = '0;
        if (en_i) begin
            // A capture on the grant cycle re-arms pend with the new sample.
            pend_d = cap | (pend_q & ~grant_i);
            win_d  = grant_i ? win_shift : win_q;
            fill_d = (grant_i && fill_q != 3'd5) ? fill_q + 3'd1 : fill_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            pdata_q <= '0;
            win_q   <= '0;
            fill_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pend_o    = pend_q;
    assign win_o     = win_shift;
    assign primed_o  = (fill_q >= 3'd4);
    assign overrun_o = ovr_q;
endmodule

module median_channel_scheduler #(
    parameter int NCH     = 4,
    parameter int ENG_LAT = 7,
    parameter int W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   chan_enable_i,
    input  logic [NCH-1:0]   in_strobe_i,
    input  logic [NCH*W-1:0] in_data_i,
    input  logic             clear_overrun_i,
    output logic [5*W-1:0]   eng_window_o,
    output logic             eng_issue_o,
    input  logic [W-1:0]     eng_result_i,
    output logic             out_valid_o,
    output logic [2:0]       out_chan_o,
    output logic [W-1:0]     out_data_o,
    output logic             out_primed_o,
    output logic [NCH-1:0]   overrun_o
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]             lane_pend, lane_primed, req, gnt_oh;
    logic [NCH-1:0][4:0][W-1:0] lane_win;
    logic                       gnt_vld;
    logic [PW-1:0]              gnt_idx, cand, ptr_q;
    logic [2:0]                 gnt_chan;
    logic                       gnt_primed;

    logic [5*W-1:0]             eng_window_q;
    logic                       eng_issue_q;
    logic [ENG_LAT-1:0]         vld_pipe_q, prm_pipe_q;
    logic [ENG_LAT-1:0][2:0]    chan_pipe_q;
    logic                       out_valid_q, out_primed_q;
    logic [2:0]                 out_chan_q;
    logic [W-1:0]               out_data_q;

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_lane
            median_chan_lane #(.W(W)) u_lane (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .en_i      (chan_enable_i[c]),
                .strobe_i  (in_strobe_i[c]),
                .data_i    (in_data_i[c*W +: W]),
                .grant_i   (gnt_oh[c]),
                .clr_ovr_i (clear_overrun_i),
                .pend_o    (lane_pend[c]),
                .win_o     (lane_win[c]),
                .primed_o  (lane_primed[c]),
                .overrun_o (overrun_o[c])
            );
        end
    endgenerate

    assign req = lane_pend & chan_enable_i;

    // Search starts one past the last grant, so every requester waits at most NCH cycles.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = PW'((int'(ptr_q) + i) % NCH);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NCH; i++)
            gnt_oh[i] = gnt_vld && (gnt_idx == PW'(i));
    end

    assign gnt_chan   = gnt_vld ? 3'(gnt_idx) : 3'd0;
    assign gnt_primed = gnt_vld & lane_primed[gnt_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q        <= PW'(NCH - 1);
            eng_window_q <= '0;
            eng_issue_q  <= 1'b0;
            vld_pipe_q   <= '0;
            chan_pipe_q  <= '0;
            prm_pipe_q   <= '0;
            out_valid_q  <= 1'b0;
            out_chan_q   <= '0;
            out_data_q   <= '0;
            out_primed_q <= 1'b0;
        end else begin
            eng_issue_q <= gnt_vld;
            if (gnt_vld) begin
                ptr_q        <= gnt_idx;
                eng_window_q <= lane_win[gnt_idx];
            end
            // Tag rides alongside the engine so the tail lines up with eng_result_i.
            vld_pipe_q   <= {vld_pipe_q[ENG_LAT-2:0], gnt_vld};
            chan_pipe_q  <= {chan_pipe_q[ENG_LAT-2:0], gnt_chan};
            prm_pipe_q   <= {prm_pipe_q[ENG_LAT-2:0], gnt_primed};
            out_valid_q  <= vld_pipe_q[ENG_LAT-1];
            out_chan_q   <= chan_pipe_q[ENG_LAT-1];
            out_primed_q <= prm_pipe_q[ENG_LAT-1];
            out_data_q   <= eng_result_i;
        end
    end

    assign eng_window_o = eng_window_q;
    assign eng_issue_o  = eng_issue_q;
    assign out_valid_o  = out_valid_q;
    assign out_chan_o   = out_chan_q;
    assign out_data_o   = out_data_q;
    assign out_primed_o = out_primed_q;
endmodule

// File: tb/tb_median_channel_scheduler.sv
// Directed bench for median_channel_scheduler: a behavioural median engine feeds the DUT,
// expectations are queued at stimulus time and a negedge monitor scores issues and results.

module tb_median_channel_scheduler;
    localparam int NCH = 4, ENG_LAT = 7, W = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [NCH-1:0]   chan_en, strobe, overrun;
    logic [NCH*W-1:0] in_data;
    logic             clr;
    logic [5*W-1:0]   eng_window;
    logic             eng_issue;
    logic [W-1:0]     eng_result;
    logic             out_valid, out_primed;
    logic [2:0]       out_chan;
    logic [W-1:0]     out_data;

    int cyc = 0, n_vec = 0, n_err = 0;

    typedef struct { int chan; int data; bit primed; int cyc; } out_t;
    typedef struct { logic [5*W-1:0] win; int cyc; } iss_t;
    out_t oq[$];
    iss_t iq[$];

    logic [W-1:0] eng_pipe [ENG_LAT-1];

    median_channel_scheduler #(.NCH(NCH), .ENG_LAT(ENG_LAT), .W(W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .chan_enable_i   (chan_en),
        .in_strobe_i     (strobe),
        .in_data_i       (in_data),
        .clear_overrun_i (clr),
        .eng_window_o    (eng_window),
        .eng_issue_o     (eng_issue),
        .eng_result_i    (eng_result),
        .out_valid_o     (out_valid),
        .out_chan_o      (out_chan),
        .out_data_o      (out_data),
        .out_primed_o    (out_primed),
        .overrun_o       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] med5(input logic [5*W-1:0] w);
        int a[5];
        int t;
        for (int i = 0; i < 5; i++) a[i] = int'($signed(w[i*W +: W]));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return W'(a[2]);
    endfunction

    // Engine: window registered by the DUT counts as capture; result ENG_LAT-1 edges later.
    always @(posedge clk) begin
        eng_pipe[0] <= med5(eng_window);
        for (int k = 1; k < ENG_LAT - 1; k++) eng_pipe[k] <= eng_pipe[k-1];
    end
    assign eng_result = eng_pipe[ENG_LAT-2];

    always @(negedge clk) begin : mon
        iss_t ei;
        out_t eo;
        if (!rst) begin
            if (eng_issue) begin
                n_vec++;
                if (iq.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: window %h at cycle %0d, none required", eng_window, cyc);
                end else begin
                    ei = iq.pop_front();
                    if (eng_window !== ei.win || cyc != ei.cyc) begin
                        n_err++;
                        $display("FAIL issue_window: got %h @%0d, required %h @%0d", eng_window, cyc, ei.win, ei.cyc);
                    end
                end
            end
            if (out_valid) begin
                n_vec++;
                if (oq.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: chan %0d data %0d at cycle %0d, none required", out_chan, $signed(out_data), cyc);
                end else begin
                    eo = oq.pop_front();
                    if (int'(out_chan) != eo.chan || int'($signed(out_data)) != eo.data ||
                        out_primed != eo.primed || cyc != eo.cyc) begin
                        n_err++;
                        $display("FAIL out_result: got ch%0d d%0d p%0d @%0d, required ch%0d d%0d p%0d @%0d",
                                 out_chan, $signed(out_data), out_primed, cyc, eo.chan, eo.data, eo.primed, eo.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe_ch(input logic [NCH-1:0] m, input int d0, input int d1, input int d2, input int d3);
        strobe  = m;
        in_data = {W'(d3), W'(d2), W'(d1), W'(d0)};
        tick();
        strobe  = '0;
    endtask

    // Window given newest first; result appears ENG_LAT cycles after the issue.
    task automatic expect_iss(input int ch, input int n0, input int n1, input int n2, input int n3,
                              input int n4, input int med, input bit prm, input int icyc);
        iss_t ei;
        out_t eo;
        ei.win = {W'(n4), W'(n3), W'(n2), W'(n1), W'(n0)};
        ei.cyc = icyc;
        iq.push_back(ei);
        eo.chan = ch; eo.data = med; eo.primed = prm; eo.cyc = icyc + ENG_LAT;
        oq.push_back(eo);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((iq.size() != 0 || oq.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check(name, iq.size() + oq.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iq.delete();
        oq.delete();
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        int base, nv;
        chan_en = '1; strobe = '0; in_data = '0; clr = 1'b0;
        for (int k = 0; k < ENG_LAT - 1; k++) eng_pipe[k] = '0;
        idle(2);
        check("reset_state", int'(|{eng_window, eng_issue, out_valid, out_chan, out_data, out_primed, overrun}), 0);
        rst = 1'b0;
        idle(1);

        // Single channel, consecutive strobes
        base = cyc;
        expect_iss(0, 10,  0,  0,   0,  0, 0, 1'b0, base + 2);
        expect_iss(0, -3, 10,  0,   0,  0, 0, 1'b0, base + 3);
        expect_iss(0,  7, -3, 10,   0,  0, 0, 1'b0, base + 4);
        expect_iss(0,  2,  7, -3,  10,  0, 2, 1'b0, base + 5);
        expect_iss(0,  9,  2,  7,  -3, 10, 7, 1'b1, base + 6);
        strobe_ch(4'b0001, 10, 0, 0, 0);
        strobe_ch(4'b0001, -3, 0, 0, 0);
        strobe_ch(4'b0001,  7, 0, 0, 0);
        strobe_ch(4'b0001,  2, 0, 0, 0);
        strobe_ch(4'b0001,  9, 0, 0, 0);
        drain("single_drain");
        do_reset();

        // Contention: two full bursts, both granted 0,1,2,3
        base = cyc;
        expect_iss(0, 11, 0, 0, 0, 0, 0, 1'b0, base + 2);
        expect_iss(1, 21, 0, 0, 0, 0, 0, 1'b0, base + 3);
        expect_iss(2, 31, 0, 0, 0, 0, 0, 1'b0, base + 4);
        expect_iss(3, 41, 0, 0, 0, 0, 0, 1'b0, base + 5);
        strobe_ch(4'b1111, 11, 21, 31, 41);
        idle(4);
        base = cyc;
        expect_iss(0, 12, 11, 0, 0, 0, 0, 1'b0, base + 2);
        expect_iss(1, 22, 21, 0, 0, 0, 0, 1'b0, base + 3);
        expect_iss(2, 32, 31, 0, 0, 0, 0, 1'b0, base + 4);
        expect_iss(3, 42, 41, 0, 0, 0, 0, 1'b0, base + 5);
        strobe_ch(4'b1111, 12, 22, 32, 42);
        drain("contention_drain");
        do_reset();

        // Overrun on ch2, then clear coinciding with a new ch1 overrun
        base = cyc;
        expect_iss(1, 101,   0, 0, 0, 0, 0, 1'b0, base + 2);
        expect_iss(2, 202,   0, 0, 0, 0, 0, 1'b0, base + 3);
        expect_iss(0,   1,   0, 0, 0, 0, 0, 1'b0, base + 4);
        expect_iss(1,   3, 101, 0, 0, 0, 0, 1'b0, base + 5);
        strobe_ch(4'b0110, 0, 101, 201, 0);
        strobe_ch(4'b0100, 0, 0, 202, 0);
        check("overrun_set", int'(overrun), 4'b0100);
        strobe_ch(4'b0011, 1, 2, 0, 0);
        clr = 1'b1;
        strobe_ch(4'b0010, 0, 3, 0, 0);
        clr = 1'b0;
        check("overrun_clear_vs_new", int'(overrun), 4'b0010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);
        drain("overrun_drain");
        do_reset();

        // Same-cycle strobe and grant on ch0
        base = cyc;
        expect_iss(0, 5, 0, 0, 0, 0, 0, 1'b0, base + 2);
        expect_iss(0, 8, 5, 0, 0, 0, 0, 1'b0, base + 3);
        strobe_ch(4'b0001, 5, 0, 0, 0);
        strobe_ch(4'b0001, 8, 0, 0, 0);
        idle(2);
        check("collision_no_overrun", int'(overrun), 0);
        drain("collision_drain");
        do_reset();

        // Disable/enable of a primed ch3 with results still in flight
        base = cyc;
        expect_iss(3,  50,  0,  0,  0,  0,  0, 1'b0, base + 2);
        expect_iss(3,  60, 50,  0,  0,  0,  0, 1'b0, base + 3);
        expect_iss(3,  70, 60, 50,  0,  0, 50, 1'b0, base + 4);
        expect_iss(3,  80, 70, 60, 50,  0, 60, 1'b0, base + 5);
        expect_iss(3,  90, 80, 70, 60, 50, 70, 1'b1, base + 6);
        expect_iss(3, 100,  0,  0,  0,  0,  0, 1'b0, base + 9);
        strobe_ch(4'b1000, 0, 0, 0, 50);
        strobe_ch(4'b1000, 0, 0, 0, 60);
        strobe_ch(4'b1000, 0, 0, 0, 70);
        strobe_ch(4'b1000, 0, 0, 0, 80);
        strobe_ch(4'b1000, 0, 0, 0, 90);
        idle(1);
        chan_en = 4'b0111;
        strobe_ch(4'b1000, 0, 0, 0, 77);
        chan_en = 4'b1111;
        strobe_ch(4'b1000, 0, 0, 0, 100);
        drain("disable_drain");

        // Reset mid-stream with results in flight
        base = cyc;
        expect_iss(0, 7, 0, 0, 0, 0, 0, 1'b0, base + 2);
        expect_iss(1, 8, 0, 0, 0, 0, 0, 1'b0, base + 3);
        expect_iss(0, 9, 7, 0, 0, 0, 0, 1'b0, base + 4);
        strobe_ch(4'b0011, 7, 8, 0, 0);
        strobe_ch(4'b0001, 9, 0, 0, 0);
        idle(3);
        check("pre_reset_newest", int'($signed(eng_window[W-1:0])), 9);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", int'(|{eng_window, eng_issue, out_valid, out_chan, out_data, out_primed, overrun}), 0);
        iq.delete();
        oq.delete();
        idle(2);
        rst = 1'b0;
        nv = 0;
        repeat (ENG_LAT + 2) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("no_valid_after_reset", nv, 0);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
